// File: rtl/dnoc_pkg.sv
// Shared types and constants for the D-channel NoC receive endpoint.
// Head flit layout, FSM state encoding and the loop-length helper live here.
package dnoc_pkg;

    localparam int FLIT_W = 256;
    localparam int ADDR_W = 13;
    localparam int LEN_W  = 13;
    localparam int LOOP_N = 4;

    // Head flit bit positions (LSB of each field)
    localparam int HD_ROUTE_LSB = 0;
    localparam int HD_RET_BIT   = 12;
    localparam int HD_SEL_BIT   = 13;
    localparam int HD_SRC_LSB   = 14;
    localparam int HD_BASE_LSB  = 18;
    localparam int HD_TGT_LSB   = 31;
    localparam int HD_LEN_LSB   = 43;
    localparam int HD_GAP_LSB   = 56;
    localparam int HD_LLEN_LSB  = 108;
    localparam int HD_SYNC_LSB  = 160;
    localparam int HD_MC_BIT    = 255;

    typedef struct packed {
        logic                            mc;
        logic [82:0]                     rsv;
        logic [11:0]                     sync;
        logic [LOOP_N-1:0][LEN_W-1:0]    loop_len;
        logic [LOOP_N-1:0][ADDR_W-1:0]   loop_gap;
        logic [LEN_W-1:0]                len;
        logic [11:0]                     tgt;
        logic [ADDR_W-1:0]               base;
        logic [3:0]                      src;
        logic                            sel;
        logic                            ret;
        logic [11:0]                     route;
    } dnoc_head_t;

    typedef enum logic [2:0] {
        HEAD  = 3'd0,
        WR    = 3'd1,
        RCORE = 3'd2,
        RDMA  = 3'd3,
        DROP  = 3'd4
    } dnoc_state_e;

    // Index of the last count of a loop level; a length of 0 behaves as 1.
    function automatic logic [LEN_W-1:0] loop_last_idx(input logic [LEN_W-1:0] len);
        return (len == '0) ? '0 : len - LEN_W'(1);
    endfunction

endpackage

// File: rtl/dnoc_loop_addr_gen.sv
// Four-level nested-loop address generator for incoming write packets.
// Level 3 is innermost; each level keeps its offset (count * gap) as a
// running sum so no multipliers are needed.
module dnoc_loop_addr_gen
    import dnoc_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          step,
    input  logic [ADDR_W-1:0]             base,
    input  logic [LOOP_N-1:0][LEN_W-1:0]  len,
    input  logic [LOOP_N-1:0][ADDR_W-1:0] gap,
    output logic [ADDR_W-1:0]             addr
);

    logic [LOOP_N-1:0][LEN_W-1:0]  cnt_q;
    logic [LOOP_N-1:0][ADDR_W-1:0] off_q;
    logic [LOOP_N-1:0]             wrap;
    logic [LOOP_N-1:0]             carry;
    logic [ADDR_W-1:0]             sum;

    // Per-level wrap detect and carry chain from the innermost level outward
    always_comb begin
        wrap  = '0;
        carry = '0;
        for (int i = 0; i < LOOP_N; i++) begin
            wrap[i] = (cnt_q[i] == loop_last_idx(len[i]));
        end
        carry[LOOP_N-1] = step;
        for (int i = LOOP_N - 1; i > 0; i--) begin
            carry[i-1] = carry[i] & wrap[i];
        end
    end

    // Counters and partial offsets advance on carry, cleared on a new head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            off_q <= '0;
        end else if (start) begin
            cnt_q <= '0;
            off_q <= '0;
        end else begin
            for (int i = 0; i < LOOP_N; i++) begin
                if (carry[i]) begin
                    if (wrap[i]) begin
                        cnt_q[i] <= '0;
                        off_q[i] <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + LEN_W'(1);
                        off_q[i] <= off_q[i] + gap[i];
                    end
                end
            end
        end
    end

    // Final address is base plus all level offsets, wrapping at the address width
    always_comb begin
        sum = base;
        for (int i = 0; i < LOOP_N; i++) begin
            sum = sum + off_q[i];
        end
    end

    assign addr = sum;

endmodule

// File: rtl/dnoc_itf_in_d_channel.sv
// Receive end of the D-channel NoC link: decodes head flits and steers body
// flits to the local write, core read-return or DMA read-return port.
// Optional beat-length checking is enabled with DNOC_IN_LEN_CHECK_EN.
module dnoc_itf_in_d_channel
    import dnoc_pkg::*;
#(
    parameter logic [3:0] NODE_ID = 4'd0,
    parameter logic [3:0] DMA_ID  = 4'b1101
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] out_flit,
    input  logic              out_last,
    input  logic              out_valid,
    output logic              out_ready,
    output logic [ADDR_W-1:0] lw_addr,
    output logic [FLIT_W-1:0] lw_data,
    output logic              lw_valid,
    output logic              lw_last,
    input  logic              lw_ready,
    output logic [FLIT_W-1:0] core_rd_noc_in_data,
    output logic              core_rd_noc_in_valid,
    output logic              core_rd_noc_in_last,
    input  logic              core_rd_noc_in_ready,
    output logic [FLIT_W-1:0] dma_wr_noc_in_data,
    output logic              dma_wr_noc_in_valid,
    output logic              dma_wr_noc_in_last,
    input  logic              dma_wr_noc_in_ready,
    output logic              hd_start,
    output logic [3:0]        hd_src_node,
    output logic              hd_src_is_dma_node,
    output logic              hd_src_dma,
    output logic [11:0]       hd_sync_target,
    output logic              err_misroute,
    output logic              err_len
);

    dnoc_state_e                   state_q, state_d;
    dnoc_head_t                    head_in;
    logic                          run_q;
    logic                          head_acc;
    logic                          body_beat;
    logic                          tgt_match;
    logic [ADDR_W-1:0]             base_q;
    logic [LOOP_N-1:0][LEN_W-1:0]  loop_len_q;
    logic [LOOP_N-1:0][ADDR_W-1:0] loop_gap_q;
    logic                          unused_head_bits;

    assign head_in   = out_flit;
    assign tgt_match = (head_in.tgt[3:0] == NODE_ID);
    assign head_acc  = (state_q == HEAD) && out_valid && out_ready;
    assign body_beat = (state_q != HEAD) && out_valid && out_ready;
    assign unused_head_bits = ^{head_in.mc, head_in.rsv, head_in.route, head_in.tgt[11:4]};

    // Link is held off during and just after reset until the first clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_q <= 1'b0;
        else        run_q <= 1'b1;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= HEAD;
        else        state_q <= state_d;
    end

    // Next-state decode and zero-latency steering of the link to one sink
    always_comb begin
        state_d              = state_q;
        out_ready            = 1'b0;
        lw_valid             = 1'b0;
        lw_last              = 1'b0;
        lw_data              = '0;
        core_rd_noc_in_valid = 1'b0;
        core_rd_noc_in_last  = 1'b0;
        core_rd_noc_in_data  = '0;
        dma_wr_noc_in_valid  = 1'b0;
        dma_wr_noc_in_last   = 1'b0;
        dma_wr_noc_in_data   = '0;
        case (state_q)
            HEAD: begin
                out_ready = run_q;
                if (out_valid && run_q && !out_last) begin
                    if (!head_in.ret) state_d = tgt_match ? WR : DROP;
                    else              state_d = head_in.sel ? RDMA : RCORE;
                end
            end
            WR: begin
                out_ready = lw_ready;
                lw_valid  = out_valid;
                lw_last   = out_last;
                lw_data   = out_flit;
                if (out_valid && lw_ready && out_last) state_d = HEAD;
            end
            RCORE: begin
                out_ready            = core_rd_noc_in_ready;
                core_rd_noc_in_valid = out_valid;
                core_rd_noc_in_last  = out_last;
                core_rd_noc_in_data  = out_flit;
                if (out_valid && core_rd_noc_in_ready && out_last) state_d = HEAD;
            end
            RDMA: begin
                out_ready           = dma_wr_noc_in_ready;
                dma_wr_noc_in_valid = out_valid;
                dma_wr_noc_in_last  = out_last;
                dma_wr_noc_in_data  = out_flit;
                if (out_valid && dma_wr_noc_in_ready && out_last) state_d = HEAD;
            end
            DROP: begin
                out_ready = 1'b1;
                if (out_valid && out_last) state_d = HEAD;
            end
            default: state_d = HEAD;
        endcase
    end

    // Latch head fields on accept; sync target only updates for return packets
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hd_src_node    <= '0;
            hd_src_dma     <= 1'b0;
            hd_sync_target <= '0;
            base_q         <= '0;
            loop_len_q     <= '0;
            loop_gap_q     <= '0;
        end else if (head_acc) begin
            hd_src_node <= head_in.src;
            hd_src_dma  <= head_in.sel;
            base_q      <= head_in.base;
            loop_len_q  <= head_in.loop_len;
            loop_gap_q  <= head_in.loop_gap;
            if (head_in.ret) hd_sync_target <= head_in.sync;
        end
    end

    // One-cycle head-accept and misroute pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hd_start     <= 1'b0;
            err_misroute <= 1'b0;
        end else begin
            hd_start     <= head_acc;
            err_misroute <= head_acc && !head_in.ret && !tgt_match;
        end
    end

    assign hd_src_is_dma_node = (hd_src_node == DMA_ID);

    dnoc_loop_addr_gen u_addr_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .start (head_acc),
        .step  ((state_q == WR) && out_valid && lw_ready),
        .base  (base_q),
        .len   (loop_len_q),
        .gap   (loop_gap_q),
        .addr  (lw_addr)
    );

`ifdef DNOC_IN_LEN_CHECK_EN
    logic [LEN_W-1:0] beat_cnt_q;
    logic [LEN_W-1:0] len_q;
    logic             len_chk_q;

    // Count body beats and flag a length mismatch the cycle after the last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
            len_q      <= '0;
            len_chk_q  <= 1'b0;
            err_len    <= 1'b0;
        end else begin
            err_len <= body_beat && out_last && len_chk_q &&
                       ((beat_cnt_q + LEN_W'(1)) != len_q);
            if (head_acc) begin
                beat_cnt_q <= '0;
                len_q      <= head_in.len;
                len_chk_q  <= !head_in.ret || (head_in.len != '0);
            end else if (body_beat) begin
                beat_cnt_q <= beat_cnt_q + LEN_W'(1);
            end
        end
    end
`else
    assign err_len = 1'b0;
`endif

endmodule
